// File: rtl/joy_pkg.sv
// Shared types and index constants for the DB9 Sega/Atari joystick poller.
// Button word layout {M,X,Y,Z,S,A,C,B,R,L,D,U}; pin layout {p9,p6,right,left,down,up}.
package joy_pkg;

  typedef logic [11:0] joy_word_t;
  typedef logic [5:0]  joy_pins_t;
  typedef logic [2:0]  joy_phase_t;

  localparam int JB_U = 0;
  localparam int JB_D = 1;
  localparam int JB_L = 2;
  localparam int JB_R = 3;
  localparam int JB_B = 4;
  localparam int JB_C = 5;
  localparam int JB_A = 6;
  localparam int JB_S = 7;
  localparam int JB_Z = 8;
  localparam int JB_Y = 9;
  localparam int JB_X = 10;
  localparam int JB_M = 11;

  localparam int PIN_UP    = 0;
  localparam int PIN_DOWN  = 1;
  localparam int PIN_LEFT  = 2;
  localparam int PIN_RIGHT = 3;
  localparam int PIN_P6    = 4;
  localparam int PIN_P9    = 5;

  localparam joy_phase_t PH_SEL_LO0 = 3'd0;
  localparam joy_phase_t PH_SEL_HI0 = 3'd1;
  localparam joy_phase_t PH_RD_CB   = 3'd2;
  localparam joy_phase_t PH_RD_SA   = 3'd3;
  localparam joy_phase_t PH_SEL_LO2 = 3'd4;
  localparam joy_phase_t PH_RD_SIX  = 3'd5;
  localparam joy_phase_t PH_RD_XYZ  = 3'd6;
  localparam joy_phase_t PH_COMMIT  = 3'd7;

  // A 6-button pad pulls all four direction pins low on its third select-low.
  function automatic logic dirs_all_low(joy_pins_t p);
    return p[PIN_RIGHT:PIN_UP] == 4'b0000;
  endfunction

endpackage

// File: rtl/joy_sega_poller_if.sv
// Pin and button-word bundle between the poller (master) and the DB9 ports / consumers (slave).
// Pure wiring; no latency, no backpressure.
interface joy_sega_poller_if;
  import joy_pkg::*;

  joy_pins_t joy1_i;
  joy_pins_t joy2_i;
  logic      joy_sel_o;
  joy_word_t joy1_o;
  joy_word_t joy2_o;
  logic      joy1_six_o;
  logic      joy2_six_o;
  logic      joy_valid_o;

  modport master (
    input  joy1_i, joy2_i,
    output joy_sel_o, joy1_o, joy2_o, joy1_six_o, joy2_six_o, joy_valid_o
  );

  modport slave (
    output joy1_i, joy2_i,
    input  joy_sel_o, joy1_o, joy2_o, joy1_six_o, joy2_six_o, joy_valid_o
  );

endinterface

// File: rtl/joy_port_decode.sv
// Per-port shadow capture and pad classification; commits on the phase-7 tick.
// Output updates one cycle after the commit tick; no backpressure (fixed schedule).
module joy_port_decode
  import joy_pkg::*;
(
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       tick,
  input  joy_phase_t phase,
  input  joy_pins_t  pins,
  output joy_word_t  word,
  output logic       six
);

  joy_word_t shadow;
  logic      six_cand;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      shadow   <= '0;
      six_cand <= 1'b0;
      word     <= '0;
      six      <= 1'b0;
    end else if (tick) begin
      case (phase)
        PH_RD_CB: begin
          shadow[JB_C:JB_U] <= ~pins;
          six_cand          <= 1'b0;
        end
        PH_RD_SA: begin
          // Left+right both low while select is low only happens on a Mega Drive pad.
          if (!pins[PIN_RIGHT] && !pins[PIN_LEFT])
            shadow[JB_S:JB_A] <= ~pins[PIN_P9:PIN_P6];
          else
            shadow[JB_S:JB_B] <= {2'b00, ~pins[PIN_P9], ~pins[PIN_P6]};
        end
        PH_RD_SIX: begin
          if (dirs_all_low(pins))
            six_cand <= 1'b1;
        end
        PH_RD_XYZ: begin
          shadow[JB_M:JB_Z] <= six_cand ? ~pins[PIN_RIGHT:PIN_UP] : 4'h0;
        end
        PH_COMMIT: begin
          word <= shadow;
          six  <= six_cand;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/joy_sega_poller.sv
// Fixed-rate Sega/Atari DB9 scanner for two ports sharing one select line; optional JOY_SYNC_EN adds a 2-flop pin synchronizer.
// Words commit atomically one cycle after the phase-7 tick (joy_valid_o); no backpressure.
module joy_sega_poller
  import joy_pkg::*;
#(
  parameter int TICK_DIV     = 384,
  parameter int PERIOD_TICKS = 128
) (
  input  logic              clk_sys,
  input  logic              reset,
  joy_sega_poller_if.master bus
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int PW = $clog2(PERIOD_TICKS);

  logic [TW-1:0] tick_cnt;
  logic [PW-1:0] phase_cnt;
  logic          tick;
  logic          in_scan;
  logic          port_tick;
  joy_phase_t    phase;
  logic          sel;
  logic          valid;
  joy_pins_t     pins1;
  joy_pins_t     pins2;
  joy_word_t     word1;
  joy_word_t     word2;
  logic          six1;
  logic          six2;

  assign tick      = (tick_cnt == TW'(TICK_DIV - 1));
  assign in_scan   = (phase_cnt < PW'(8));
  assign phase     = phase_cnt[2:0];
  assign port_tick = tick && in_scan;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      phase_cnt <= '0;
    end else if (tick) begin
      if (phase_cnt == PW'(PERIOD_TICKS - 1))
        phase_cnt <= '0;
      else
        phase_cnt <= phase_cnt + PW'(1);
    end
  end

  // Even scan phases drive select low, odd ones high; the idle tail holds it high.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sel <= 1'b1;
    end else if (tick) begin
      sel <= in_scan ? phase[0] : 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      valid <= 1'b0;
    end else begin
      valid <= port_tick && (phase == PH_COMMIT);
    end
  end

`ifdef JOY_SYNC_EN
  joy_pins_t sync1_q1;
  joy_pins_t sync1_q2;
  joy_pins_t sync2_q1;
  joy_pins_t sync2_q2;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1_q1 <= '1;
      sync1_q2 <= '1;
      sync2_q1 <= '1;
      sync2_q2 <= '1;
    end else begin
      sync1_q1 <= bus.joy1_i;
      sync1_q2 <= sync1_q1;
      sync2_q1 <= bus.joy2_i;
      sync2_q2 <= sync2_q1;
    end
  end

  assign pins1 = sync1_q2;
  assign pins2 = sync2_q2;
`else
  assign pins1 = bus.joy1_i;
  assign pins2 = bus.joy2_i;
`endif

  joy_port_decode u_port1 (
    .clk_sys (clk_sys),
    .reset   (reset),
    .tick    (port_tick),
    .phase   (phase),
    .pins    (pins1),
    .word    (word1),
    .six     (six1)
  );

  joy_port_decode u_port2 (
    .clk_sys (clk_sys),
    .reset   (reset),
    .tick    (port_tick),
    .phase   (phase),
    .pins    (pins2),
    .word    (word2),
    .six     (six2)
  );

  assign bus.joy_sel_o   = sel;
  assign bus.joy_valid_o = valid;
  assign bus.joy1_o      = word1;
  assign bus.joy2_o      = word2;
  assign bus.joy1_six_o  = six1;
  assign bus.joy2_six_o  = six2;

endmodule
